data_memory_arbiter: RTL

//  Shares the single-port data memory between the CPU control/datapath and an external

---
 rtl/data_memory_arbiter_pkg.sv | 25 ++
 rtl/data_memory_arbiter_read_return_tracker.sv | 38 +++
 rtl/data_memory_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/data_memory_arbiter_pkg.sv
// Shared types and default widths for the data memory arbiter.
package data_memory_arbiter_pkg;

  localparam int unsigned DEF_OPERAND_WIDTH = 11;
  localparam int unsigned DEF_DATA_WIDTH    = 16;
  localparam int unsigned DEF_LOCK_LIMIT    = 8;

  typedef enum logic [1:0] {
    ARB,
    CPU_ISSUE,
    EXT_ISSUE
  } arb_state_t;

  typedef enum logic {
    OWNER_CPU,
    OWNER_EXT
  } owner_t;

  // Tag travelling with an issued read until its data returns.
  typedef struct packed {
    logic   valid;
    owner_t owner;
  } rd_tag_t;

endpackage

// File: rtl/data_memory_arbiter_read_return_tracker.sv
// Tracks issued reads and steers returning memory data to the owning requester.
module read_return_tracker
  import data_memory_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clock_in,
  input  logic                  reset_in,
  input  logic                  issue_rd,
  input  owner_t                issue_owner,
  input  logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  cpu_rvalid_out,
  output logic [DATA_WIDTH-1:0] cpu_data_out,
  output logic                  ext_rvalid_out,
  output logic [DATA_WIDTH-1:0] ext_data_out
);

  rd_tag_t tag_q;

  // Stage 1 tags the cycle the memory returns data; stage 2 presents it to the owner.
  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      tag_q          <= '0;
      cpu_rvalid_out <= 1'b0;
      ext_rvalid_out <= 1'b0;
      cpu_data_out   <= '0;
      ext_data_out   <= '0;
    end else begin
      tag_q.valid    <= issue_rd;
      tag_q.owner    <= issue_owner;
      cpu_rvalid_out <= tag_q.valid && (tag_q.owner == OWNER_CPU);
      ext_rvalid_out <= tag_q.valid && (tag_q.owner == OWNER_EXT);
      if (tag_q.valid && (tag_q.owner == OWNER_CPU)) cpu_data_out <= mem_data_in;
      if (tag_q.valid && (tag_q.owner == OWNER_EXT)) ext_data_out <= mem_data_in;
    end
  end

endmodule

// File: rtl/data_memory_arbiter.sv
// Arbitrates the single-port data memory between the CPU and the external loader port.
module data_memory_arbiter
  import data_memory_arbiter_pkg::*;
#(
  parameter int unsigned OPERAND_WIDTH = DEF_OPERAND_WIDTH,
  parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int unsigned LOCK_LIMIT    = DEF_LOCK_LIMIT
) (
  input  logic                     clock_in,
  input  logic                     reset_in,
  input  logic                     cpu_req_in,
  input  logic                     cpu_wr_in,
  input  logic [OPERAND_WIDTH-1:0] cpu_addr_in,
  input  logic [DATA_WIDTH-1:0]    cpu_data_in,
  output logic                     cpu_ack_out,
  output logic                     cpu_rvalid_out,
  output logic [DATA_WIDTH-1:0]    cpu_data_out,
  input  logic                     ext_req_in,
  input  logic                     ext_wr_in,
  input  logic [OPERAND_WIDTH-1:0] ext_addr_in,
  input  logic [DATA_WIDTH-1:0]    ext_data_in,
  input  logic                     ext_lock_in,
  output logic                     ext_ack_out,
  output logic                     ext_rvalid_out,
  output logic [DATA_WIDTH-1:0]    ext_data_out,
  output logic                     mem_en_out,
  output logic                     mem_wr_out,
  output logic [OPERAND_WIDTH-1:0] mem_addr_out,
  output logic [DATA_WIDTH-1:0]    mem_data_out,
  input  logic [DATA_WIDTH-1:0]    mem_data_in
);

  localparam int unsigned CNT_W = $clog2(LOCK_LIMIT + 1);

  arb_state_t             state_q, state_d;
  owner_t                 last_owner_q, last_owner_d;
  logic [CNT_W-1:0]       lock_cnt_q, lock_cnt_d;
  logic                   cpu_elig_c, ext_elig_c, lock_full_c, lock_hold_c;
  logic                   mem_wr_d;
  logic [OPERAND_WIDTH-1:0] mem_addr_d;
  logic [DATA_WIDTH-1:0]  mem_data_d;
  owner_t                 issue_owner_c;

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q      <= ARB;
      last_owner_q <= OWNER_EXT;
      lock_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      lock_cnt_q   <= lock_cnt_d;
    end
  end

  // Grant selection; a requester is ignored during its own ack cycle.
  always_comb begin
    state_d      = ARB;
    last_owner_d = last_owner_q;
    lock_cnt_d   = lock_cnt_q;
    mem_wr_d     = 1'b0;
    mem_addr_d   = '0;
    mem_data_d   = '0;
    cpu_elig_c   = cpu_req_in && !cpu_ack_out;
    ext_elig_c   = ext_req_in && !ext_ack_out;
    lock_full_c  = (lock_cnt_q == CNT_W'(LOCK_LIMIT));
    // While locked and under the limit, the CPU is held off even in ext's bubble cycle.
    lock_hold_c  = ext_lock_in && ext_req_in && !lock_full_c;

    if (lock_hold_c) begin
      if (ext_elig_c) state_d = EXT_ISSUE;
    end else if (cpu_elig_c && ext_elig_c) begin
      state_d = (ext_lock_in || last_owner_q == OWNER_EXT) ? CPU_ISSUE : EXT_ISSUE;
    end else if (cpu_elig_c) begin
      state_d = CPU_ISSUE;
    end else if (ext_elig_c) begin
      state_d = EXT_ISSUE;
    end

    case (state_d)
      CPU_ISSUE: begin
        last_owner_d = OWNER_CPU;
        mem_wr_d     = cpu_wr_in;
        mem_addr_d   = cpu_addr_in;
        mem_data_d   = cpu_data_in;
      end
      EXT_ISSUE: begin
        last_owner_d = OWNER_EXT;
        mem_wr_d     = ext_wr_in;
        mem_addr_d   = ext_addr_in;
        mem_data_d   = ext_data_in;
      end
      default: ;
    endcase

    if (!ext_lock_in || !cpu_req_in || state_d == CPU_ISSUE) begin
      lock_cnt_d = '0;
    end else if (state_d == EXT_ISSUE && !lock_full_c) begin
      lock_cnt_d = lock_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      cpu_ack_out  <= 1'b0;
      ext_ack_out  <= 1'b0;
      mem_en_out   <= 1'b0;
      mem_wr_out   <= 1'b0;
      mem_addr_out <= '0;
      mem_data_out <= '0;
    end else begin
      cpu_ack_out  <= (state_d == CPU_ISSUE);
      ext_ack_out  <= (state_d == EXT_ISSUE);
      mem_en_out   <= (state_d != ARB);
      mem_wr_out   <= mem_wr_d;
      mem_addr_out <= mem_addr_d;
      mem_data_out <= mem_data_d;
    end
  end

  assign issue_owner_c = (state_q == EXT_ISSUE) ? OWNER_EXT : OWNER_CPU;

  read_return_tracker #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_tracker (
    .clock_in      (clock_in),
    .reset_in      (reset_in),
    .issue_rd      (mem_en_out && !mem_wr_out),
    .issue_owner   (issue_owner_c),
    .mem_data_in   (mem_data_in),
    .cpu_rvalid_out(cpu_rvalid_out),
    .cpu_data_out  (cpu_data_out),
    .ext_rvalid_out(ext_rvalid_out),
    .ext_data_out  (ext_data_out)
  );

endmodule
